// File: rtl/bp_be_dcache_event_profiler.sv
// rtl/bp_be_dcache_event_profiler.sv - on-chip event counters, miss-latency histogram and miss ring for the BE dcache
//
// Ports:
//   clk_i, reset_i (sync, active-high), clear_i (same effect as reset), freeze_i (ignore all events)
//   access_v_i/load_i/store_i, data_mem_read_i/data_mem_write_i : access and per-way activity taps
//   cache_req_yumi_i/cache_req_last_i/paddr_i                  : miss start/finish taps
//   rd_v_i/rd_addr_i -> rd_v_o/rd_data_o                       : registered counter read port
//   trace_idx_i -> trace_paddr_o/trace_lat_o, trace_count_o    : combinational miss ring read port
//   miss_busy_o                                                : a miss is being timed
module bp_be_dcache_event_profiler #(
    parameter int assoc_p       = 8,
    parameter int paddr_width_p = 40,
    parameter int ctr_width_p   = 32,
    parameter int hist_bins_p   = 8,
    parameter int bin_shift_p   = 2,
    parameter int trace_depth_p = 16,
    localparam int num_ctr_lp         = 6 + hist_bins_p + 2 * assoc_p,
    localparam int ctr_addr_width_lp  = $clog2(num_ctr_lp),
    localparam int trace_idx_width_lp = $clog2(trace_depth_p)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          freeze_i,
    input  logic                          clear_i,
    input  logic                          access_v_i,
    input  logic                          load_i,
    input  logic                          store_i,
    input  logic [paddr_width_p-1:0]      paddr_i,
    input  logic                          cache_req_yumi_i,
    input  logic                          cache_req_last_i,
    input  logic [assoc_p-1:0]            data_mem_read_i,
    input  logic [assoc_p-1:0]            data_mem_write_i,
    input  logic                          rd_v_i,
    input  logic [ctr_addr_width_lp-1:0]  rd_addr_i,
    output logic                          rd_v_o,
    output logic [ctr_width_p-1:0]        rd_data_o,
    input  logic [trace_idx_width_lp-1:0] trace_idx_i,
    output logic [paddr_width_p-1:0]      trace_paddr_o,
    output logic [ctr_width_p-1:0]        trace_lat_o,
    output logic [trace_idx_width_lp:0]   trace_count_o,
    output logic                          miss_busy_o
);

    localparam int ctr_access_lp   = 0;
    localparam int ctr_load_lp     = 1;
    localparam int ctr_store_lp    = 2;
    localparam int ctr_miss_lp     = 3;
    localparam int ctr_miss_cyc_lp = 4;
    localparam int ctr_overlap_lp  = 5;
    localparam int ctr_hist_lp     = 6;
    localparam int ctr_rd_way_lp   = 6 + hist_bins_p;
    localparam int ctr_wr_way_lp   = 6 + hist_bins_p + assoc_p;

    localparam logic [ctr_width_p-1:0]        one_lp   = ctr_width_p'(1);
    localparam logic [trace_idx_width_lp:0]   depth_lp = (trace_idx_width_lp + 1)'(trace_depth_p);

    localparam logic [0:0] idle_s = 1'b0;
    localparam logic [0:0] wait_s = 1'b1;

    function automatic logic [ctr_width_p-1:0] sat_add(input logic [ctr_width_p-1:0] a,
                                                      input logic [ctr_width_p-1:0] b);
        logic [ctr_width_p:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[ctr_width_p] ? '1 : s[ctr_width_p-1:0];
    endfunction

    logic [ctr_width_p-1:0]        ctr_q [num_ctr_lp];
    logic [ctr_width_p-1:0]        ctr_d [num_ctr_lp];
    logic [0:0]                    state_q, state_d;
    logic [ctr_width_p-1:0]        lat_q, lat_d;
    logic [paddr_width_p-1:0]      miss_paddr_q, miss_paddr_d;
    logic [trace_idx_width_lp-1:0] wptr_q, wptr_d;
    logic [trace_idx_width_lp:0]   count_q, count_d;
    logic [paddr_width_p-1:0]      ring_paddr_q [trace_depth_p];
    logic [paddr_width_p-1:0]      ring_paddr_d [trace_depth_p];
    logic [ctr_width_p-1:0]        ring_lat_q [trace_depth_p];
    logic [ctr_width_p-1:0]        ring_lat_d [trace_depth_p];
    logic                          rd_v_q, rd_v_d;
    logic [ctr_width_p-1:0]        rd_data_q, rd_data_d;

    logic                          complete;
    logic [ctr_width_p-1:0]        comp_lat;
    logic [paddr_width_p-1:0]      comp_paddr;
    logic [ctr_width_p-1:0]        lat_shifted;
    int                            bin_idx;
    logic [trace_idx_width_lp-1:0] trace_sel;

    always_comb begin
        ctr_d        = ctr_q;
        state_d      = state_q;
        lat_d        = lat_q;
        miss_paddr_d = miss_paddr_q;
        wptr_d       = wptr_q;
        count_d      = count_q;
        ring_paddr_d = ring_paddr_q;
        ring_lat_d   = ring_lat_q;
        complete     = 1'b0;
        comp_lat     = '0;
        comp_paddr   = '0;
        lat_shifted  = '0;
        bin_idx      = 0;

        if (!freeze_i) begin
            if (access_v_i) begin
                ctr_d[ctr_access_lp] = sat_add(ctr_d[ctr_access_lp], one_lp);
                if (load_i)  ctr_d[ctr_load_lp]  = sat_add(ctr_d[ctr_load_lp], one_lp);
                if (store_i) ctr_d[ctr_store_lp] = sat_add(ctr_d[ctr_store_lp], one_lp);
            end
            for (int i = 0; i < assoc_p; i++) begin
                if (data_mem_read_i[i])
                    ctr_d[ctr_rd_way_lp+i] = sat_add(ctr_d[ctr_rd_way_lp+i], one_lp);
                if (data_mem_write_i[i])
                    ctr_d[ctr_wr_way_lp+i] = sat_add(ctr_d[ctr_wr_way_lp+i], one_lp);
            end
        end

        case (state_q)
            idle_s: begin
                // A fill whose last beat arrives with the request itself took no wait cycles.
                if (!freeze_i && cache_req_yumi_i) begin
                    if (cache_req_last_i) begin
                        complete   = 1'b1;
                        comp_lat   = '0;
                        comp_paddr = paddr_i;
                    end else begin
                        miss_paddr_d = paddr_i;
                        lat_d        = one_lp;
                        state_d      = wait_s;
                    end
                end
            end
            default: begin
                if (freeze_i) begin
                    // An in-flight miss cut by a freeze would record a bogus latency.
                    state_d = idle_s;
                    lat_d   = '0;
                end else begin
                    if (cache_req_yumi_i)
                        ctr_d[ctr_overlap_lp] = sat_add(ctr_d[ctr_overlap_lp], one_lp);
                    if (cache_req_last_i) begin
                        complete   = 1'b1;
                        comp_lat   = lat_q;
                        comp_paddr = miss_paddr_q;
                        state_d    = idle_s;
                        lat_d      = '0;
                    end else begin
                        lat_d = sat_add(lat_q, one_lp);
                    end
                end
            end
        endcase

        if (complete) begin
            ctr_d[ctr_miss_lp]     = sat_add(ctr_d[ctr_miss_lp], one_lp);
            ctr_d[ctr_miss_cyc_lp] = sat_add(ctr_d[ctr_miss_cyc_lp], comp_lat);
            lat_shifted = comp_lat >> bin_shift_p;
            if (lat_shifted >= ctr_width_p'(hist_bins_p - 1))
                bin_idx = hist_bins_p - 1;
            else
                bin_idx = int'(lat_shifted);
            ctr_d[ctr_hist_lp+bin_idx] = sat_add(ctr_d[ctr_hist_lp+bin_idx], one_lp);
            ring_paddr_d[wptr_q] = comp_paddr;
            ring_lat_d[wptr_q]   = comp_lat;
            wptr_d = wptr_q + trace_idx_width_lp'(1);
            if (count_q != depth_lp)
                count_d = count_q + (trace_idx_width_lp + 1)'(1);
        end
    end

    // Read data reflects the counters as registered before this cycle's updates.
    always_comb begin
        rd_v_d    = rd_v_i;
        rd_data_d = rd_data_q;
        if (rd_v_i) begin
            if (int'(rd_addr_i) < num_ctr_lp)
                rd_data_d = ctr_q[rd_addr_i];
            else
                rd_data_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            for (int i = 0; i < num_ctr_lp; i++) ctr_q[i] <= '0;
            for (int i = 0; i < trace_depth_p; i++) begin
                ring_paddr_q[i] <= '0;
                ring_lat_q[i]   <= '0;
            end
            state_q      <= idle_s;
            lat_q        <= '0;
            miss_paddr_q <= '0;
            wptr_q       <= '0;
            count_q      <= '0;
            rd_v_q       <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            ctr_q        <= ctr_d;
            ring_paddr_q <= ring_paddr_d;
            ring_lat_q   <= ring_lat_d;
            state_q      <= state_d;
            lat_q        <= lat_d;
            miss_paddr_q <= miss_paddr_d;
            wptr_q       <= wptr_d;
            count_q      <= count_d;
            rd_v_q       <= rd_v_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Index 0 is the most recently written entry, i.e. one behind the write pointer.
    always_comb begin
        trace_sel     = wptr_q - trace_idx_width_lp'(1) - trace_idx_i;
        trace_paddr_o = '0;
        trace_lat_o   = '0;
        if ({1'b0, trace_idx_i} < count_q) begin
            trace_paddr_o = ring_paddr_q[trace_sel];
            trace_lat_o   = ring_lat_q[trace_sel];
        end
    end

    assign rd_v_o        = rd_v_q;
    assign rd_data_o     = rd_data_q;
    assign trace_count_o = count_q;
    assign miss_busy_o   = (state_q == wait_s);

endmodule

// File: tb/tb_bp_be_dcache_event_profiler.sv
// tb/tb_bp_be_dcache_event_profiler.sv - directed self-checking bench for bp_be_dcache_event_profiler
module tb_bp_be_dcache_event_profiler;

    localparam int AW = 5;
    localparam int CW = 8;
    localparam int PW = 40;
    localparam int TW = 4;

    logic          clk = 1'b0;
    logic          reset_i, freeze_i, clear_i;
    logic          access_v_i, load_i, store_i;
    logic [PW-1:0] paddr_i;
    logic          yumi_i, last_i;
    logic [7:0]    dm_rd_i, dm_wr_i;
    logic          rd_v_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_v_o;
    logic [CW-1:0] rd_data_o;
    logic [TW-1:0] trace_idx_i;
    logic [PW-1:0] trace_paddr_o;
    logic [CW-1:0] trace_lat_o;
    logic [TW:0]   trace_count_o;
    logic          miss_busy_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bp_be_dcache_event_profiler #(
        .assoc_p(8), .paddr_width_p(PW), .ctr_width_p(CW),
        .hist_bins_p(8), .bin_shift_p(2), .trace_depth_p(16)
    ) dut (
        .clk_i(clk), .reset_i(reset_i), .freeze_i(freeze_i), .clear_i(clear_i),
        .access_v_i(access_v_i), .load_i(load_i), .store_i(store_i), .paddr_i(paddr_i),
        .cache_req_yumi_i(yumi_i), .cache_req_last_i(last_i),
        .data_mem_read_i(dm_rd_i), .data_mem_write_i(dm_wr_i),
        .rd_v_i(rd_v_i), .rd_addr_i(rd_addr_i), .rd_v_o(rd_v_o), .rd_data_o(rd_data_o),
        .trace_idx_i(trace_idx_i), .trace_paddr_o(trace_paddr_o), .trace_lat_o(trace_lat_o),
        .trace_count_o(trace_count_o), .miss_busy_o(miss_busy_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        freeze_i = 0; clear_i = 0; access_v_i = 0; load_i = 0; store_i = 0;
        paddr_i = '0; yumi_i = 0; last_i = 0; dm_rd_i = '0; dm_wr_i = '0;
        rd_v_i = 0; rd_addr_i = '0; trace_idx_i = '0;
    endtask

    task automatic do_clear();
        clear_i = 1; step(); clear_i = 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [CW-1:0] d, output logic v);
        rd_v_i = 1; rd_addr_i = a;
        step();
        v = rd_v_o; d = rd_data_o;
        rd_v_i = 0;
    endtask

    task automatic do_miss(input logic [PW-1:0] pa, input int lat);
        paddr_i = pa; yumi_i = 1;
        if (lat == 0) begin
            last_i = 1; step(); last_i = 0; yumi_i = 0;
        end else begin
            step(); yumi_i = 0; paddr_i = '0;
            for (int k = 1; k < lat; k++) step();
            last_i = 1; step(); last_i = 0;
        end
    endtask

    task automatic test_reset();
        logic [CW-1:0] d; logic v;
        checks++; if (rd_v_o !== 1'b0) begin errors++; $display("FAIL reset_rd_v got %0b want 0", rd_v_o); end
        checks++; if (rd_data_o !== 8'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data_o); end
        checks++; if (miss_busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", miss_busy_o); end
        checks++; if (trace_count_o !== 5'd0) begin errors++; $display("FAIL reset_tcount got %0d want 0", trace_count_o); end
        do_read(5'd0, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL reset_ctr0 got %0d want 0", d); end
    endtask

    task automatic test_access_counts();
        logic [CW-1:0] d; logic v;
        do_clear();
        access_v_i = 1;
        load_i = 1;
        repeat (3) step();
        load_i = 0; store_i = 1;
        repeat (2) step();
        store_i = 0; load_i = 1; freeze_i = 1; dm_wr_i = 8'h80;
        step();
        freeze_i = 0; load_i = 0; access_v_i = 0; dm_wr_i = '0;
        dm_rd_i = 8'b0000_0101; step();
        dm_rd_i = 8'b0000_0001; step();
        dm_rd_i = '0;
        checks++; if (rd_v_o !== 1'b0) begin errors++; $display("FAIL rd_v_idle got %0b want 0", rd_v_o); end
        do_read(5'd0, d, v);
        checks++; if (v !== 1'b1) begin errors++; $display("FAIL rd_v_latency got %0b want 1", v); end
        checks++; if (d !== 8'd5) begin errors++; $display("FAIL ctr_access got %0d want 5", d); end
        do_read(5'd1, d, v);
        checks++; if (d !== 8'd3) begin errors++; $display("FAIL ctr_load got %0d want 3", d); end
        do_read(5'd2, d, v);
        checks++; if (d !== 8'd2) begin errors++; $display("FAIL ctr_store got %0d want 2", d); end
        step();
        checks++; if (rd_v_o !== 1'b0 || rd_data_o !== 8'd2) begin errors++; $display("FAIL rd_hold got v=%0b d=%0d want v=0 d=2", rd_v_o, rd_data_o); end
        do_read(5'd14, d, v);
        checks++; if (d !== 8'd2) begin errors++; $display("FAIL way0_rd got %0d want 2", d); end
        do_read(5'd16, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL way2_rd got %0d want 1", d); end
        do_read(5'd29, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL way7_wr_frozen got %0d want 0", d); end
    endtask

    task automatic test_miss_latency();
        logic [CW-1:0] d; logic v;
        do_clear();
        paddr_i = 40'h00_8000_0040; yumi_i = 1;
        step();
        yumi_i = 0; paddr_i = '0;
        for (int k = 0; k < 4; k++) begin
            checks++; if (miss_busy_o !== 1'b1) begin errors++; $display("FAIL busy_wait%0d got %0b want 1", k, miss_busy_o); end
            step();
        end
        checks++; if (miss_busy_o !== 1'b1) begin errors++; $display("FAIL busy_last got %0b want 1", miss_busy_o); end
        last_i = 1; step(); last_i = 0;
        checks++; if (miss_busy_o !== 1'b0) begin errors++; $display("FAIL busy_done got %0b want 0", miss_busy_o); end
        do_read(5'd3, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL miss_ctr got %0d want 1", d); end
        do_read(5'd4, d, v);
        checks++; if (d !== 8'd5) begin errors++; $display("FAIL miss_cyc got %0d want 5", d); end
        do_read(5'd7, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL hist_bin1 got %0d want 1", d); end
        trace_idx_i = 0; #1;
        checks++; if (trace_paddr_o !== 40'h00_8000_0040 || trace_lat_o !== 8'd5) begin errors++; $display("FAIL trace0 got %h/%0d want 80000040/5", trace_paddr_o, trace_lat_o); end
        checks++; if (trace_count_o !== 5'd1) begin errors++; $display("FAIL tcount1 got %0d want 1", trace_count_o); end
        trace_idx_i = 1; #1;
        checks++; if (trace_paddr_o !== 40'd0 || trace_lat_o !== 8'd0) begin errors++; $display("FAIL trace_invalid got %h/%0d want 0/0", trace_paddr_o, trace_lat_o); end
        trace_idx_i = 0;
    endtask

    task automatic test_same_cycle_and_clamp();
        logic [CW-1:0] d; logic v;
        do_clear();
        do_miss(40'h1234, 0);
        checks++; if (miss_busy_o !== 1'b0) begin errors++; $display("FAIL zero_lat_busy got %0b want 0", miss_busy_o); end
        do_read(5'd6, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL hist_bin0 got %0d want 1", d); end
        do_read(5'd4, d, v);
        checks++; if (d !== 8'd0) begin errors++; $display("FAIL zero_lat_cyc got %0d want 0", d); end
        #1;
        checks++; if (trace_lat_o !== 8'd0 || trace_paddr_o !== 40'h1234) begin errors++; $display("FAIL zero_lat_trace got %h/%0d want 1234/0", trace_paddr_o, trace_lat_o); end
        do_miss(40'h5678, 100);
        do_read(5'd13, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL hist_clamp got %0d want 1", d); end
        do_read(5'd4, d, v);
        checks++; if (d !== 8'd100) begin errors++; $display("FAIL lat100_cyc got %0d want 100", d); end
        do_read(5'd3, d, v);
        checks++; if (d !== 8'd2) begin errors++; $display("FAIL two_misses got %0d want 2", d); end
    endtask

    task automatic test_ring_wrap();
        logic [CW-1:0] d; logic v;
        do_clear();
        for (int l = 1; l <= 18; l++) do_miss(40'h1000 + 40'(l), l);
        checks++; if (trace_count_o !== 5'd16) begin errors++; $display("FAIL ring_count got %0d want 16", trace_count_o); end
        trace_idx_i = 0; #1;
        checks++; if (trace_lat_o !== 8'd18 || trace_paddr_o !== 40'h1012) begin errors++; $display("FAIL ring_idx0 got %h/%0d want 1012/18", trace_paddr_o, trace_lat_o); end
        trace_idx_i = 2; #1;
        checks++; if (trace_lat_o !== 8'd16) begin errors++; $display("FAIL ring_idx2_wrap got %0d want 16", trace_lat_o); end
        trace_idx_i = 15; #1;
        checks++; if (trace_lat_o !== 8'd3 || trace_paddr_o !== 40'h1003) begin errors++; $display("FAIL ring_idx15 got %h/%0d want 1003/3", trace_paddr_o, trace_lat_o); end
        trace_idx_i = 0;
        do_read(5'd4, d, v);
        checks++; if (d !== 8'd171) begin errors++; $display("FAIL ring_cyc_sum got %0d want 171", d); end
    endtask

    task automatic test_overlap_and_freeze();
        logic [CW-1:0] d; logic v;
        do_clear();
        paddr_i = 40'hAAAA; yumi_i = 1; step();
        yumi_i = 0; paddr_i = '0; step(); step();
        paddr_i = 40'hBBBB; yumi_i = 1; step();
        yumi_i = 0; paddr_i = '0; step();
        last_i = 1; step(); last_i = 0;
        do_read(5'd5, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL overlap_ctr got %0d want 1", d); end
        checks++; if (trace_paddr_o !== 40'hAAAA || trace_lat_o !== 8'd5) begin errors++; $display("FAIL overlap_keep got %h/%0d want aaaa/5", trace_paddr_o, trace_lat_o); end
        paddr_i = 40'hCCCC; yumi_i = 1; step();
        yumi_i = 0; paddr_i = '0; step();
        freeze_i = 1; step(); freeze_i = 0;
        checks++; if (miss_busy_o !== 1'b0) begin errors++; $display("FAIL freeze_idle got %0b want 0", miss_busy_o); end
        last_i = 1; step(); last_i = 0;
        do_read(5'd3, d, v);
        checks++; if (d !== 8'd1) begin errors++; $display("FAIL freeze_no_complete got %0d want 1", d); end
        checks++; if (trace_count_o !== 5'd1) begin errors++; $display("FAIL freeze_tcount got %0d want 1", trace_count_o); end
    endtask

    task automatic test_saturation_and_clear();
        logic [CW-1:0] d; logic v;
        do_clear();
        access_v_i = 1; dm_wr_i = 8'hFF;
        repeat (255) step();
        access_v_i = 0; dm_wr_i = '0;
        do_read(5'd0, d, v);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL preload_ctr0 got %0d want 255", d); end
        access_v_i = 1; dm_wr_i = 8'hFF; step();
        access_v_i = 0; dm_wr_i = '0;
        do_read(5'd0, d, v);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL sat_ctr0 got %0d want 255", d); end
        do_read(5'd29, d, v);
        checks++; if (d !== 8'hFF) begin errors++; $display("FAIL sat_way7_wr got %0d want 255", d); end
        do_read(5'd30, d, v);
        checks++; if (d !== 8'd0 || v !== 1'b1) begin errors++; $display("FAIL rd_oob got v=%0b d=%0d want v=1 d=0", v, d); end
        do_read(5'd0, d, v);
        clear_i = 1; access_v_i = 1; paddr_i = 40'h77; yumi_i = 1; step();
        clear_i = 0; access_v_i = 0; paddr_i = '0; yumi_i = 0;
        checks++; if (rd_data_o !== 8'd0 || rd_v_o !== 1'b0) begin errors++; $display("FAIL clear_rd_port got v=%0b d=%0d want 0/0", rd_v_o, rd_data_o); end
        checks++; if (miss_busy_o !== 1'b0 || trace_count_o !== 5'd0) begin errors++; $display("FAIL clear_fsm got busy=%0b cnt=%0d want 0/0", miss_busy_o, trace_count_o); end
        for (int a = 0; a < 30; a++) begin
            do_read(AW'(a), d, v);
            checks++; if (d !== 8'd0) begin errors++; $display("FAIL clear_ctr%0d got %0d want 0", a, d); end
        end
    endtask

    initial begin
        idle_inputs();
        reset_i = 1;
        step(); step();
        reset_i = 0;
        test_reset();
        test_access_counts();
        test_miss_latency();
        test_same_cycle_and_clamp();
        test_ring_wrap();
        test_overlap_and_freeze();
        test_saturation_and_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_be_dcache_event_profiler.md
Name: bp_be_dcache_event_profiler

Overview:
Synthesizable, parametrised event profiler for the BE dcache. It replaces file-based trace output with on-chip state: saturating event counters, per-way data-memory activity counters, a miss-latency FSM with a histogram, and a ring buffer of recent misses. Its inputs tap dcache/engine handshake signals. A registered read port exposes the counters to debug or CSR logic.

Parameters:
assoc_p, 8, dcache ways; sets the number of per-way counters
paddr_width_p, 40, physical address width
ctr_width_p, 32, width of every counter and of the latency accumulator
hist_bins_p, 8, number of latency histogram bins (>=2)
bin_shift_p, 2, latency right-shift applied before binning
trace_depth_p, 16, miss ring buffer entries (power of 2)
Derived: num_ctr_lp = 6+hist_bins_p+2*assoc_p; ctr_addr_width_lp = clog2(num_ctr_lp); trace_idx_width_lp = clog2(trace_depth_p)

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
freeze_i  in  1  when high, all event inputs are ignored
clear_i  in  1  zeroes counters, ring and FSM (same effect as reset)
access_v_i  in  1  dcache packet accepted (ready_and & v)
load_i  in  1  qualifies access_v_i as a load
store_i  in  1  qualifies access_v_i as a store
paddr_i  in  paddr_width_p  TV-stage physical address
cache_req_yumi_i  in  1  miss request accepted by engine
cache_req_last_i  in  1  final fill beat of the miss
data_mem_read_i  in  assoc_p  per-way data mem read (fast|slow)
data_mem_write_i  in  assoc_p  per-way data mem write (fast|slow)
rd_v_i  in  1  counter read request
rd_addr_i  in  ctr_addr_width_lp  counter index
rd_v_o  out  1  read data valid
rd_data_o  out  ctr_width_p  counter value
trace_idx_i  in  trace_idx_width_lp  ring entry index; 0 = newest
trace_paddr_o  out  paddr_width_p  paddr of the selected entry (combinational)
trace_lat_o  out  ctr_width_p  latency of the selected entry (combinational)
trace_count_o  out  trace_idx_width_lp+1  number of valid entries, saturating at trace_depth_p
miss_busy_o  out  1  FSM is in WAIT

Behaviour:
- Reset/clear: every counter, ring entry, write pointer, trace_count_o, rd_v_o, rd_data_o and miss_busy_o go to 0; FSM goes to IDLE. clear_i has priority over any event in the same cycle.
- Counter map:
  - 0 accesses; 1 loads; 2 stores; 3 misses completed
  - 4 total miss cycles; 5 overlap errors
  - 6..6+H-1 histogram bins
  - next assoc_p entries: way reads; next assoc_p entries: way writes
- All counters saturate at all-ones and never wrap.
- Counters 0–2 and the way counters increment by 1 per cycle per asserted bit when freeze_i=0. Multiple way bits in one cycle update their respective counters independently.
- Miss FSM, IDLE/WAIT, with latency register lat_r:
  - IDLE & yumi & !last: capture paddr_i, set lat_r=1, go to WAIT.
  - IDLE & yumi & last: complete immediately with latency 0; stay in IDLE.
  - WAIT & !last: lat_r increments (saturating).
  - WAIT & last: complete with latency lat_r; go to IDLE.
  - WAIT & yumi: overlap-error counter increments; the current miss is kept.
  - last while IDLE without yumi: ignored.
- Completion:
  - miss counter +1; miss-cycle counter += latency (saturating)
  - bin = min(latency>>bin_shift_p, hist_bins_p-1); that bin +1
  - ring[wptr] = {paddr, latency}; wptr increments and wraps modulo trace_depth_p; trace_count_o increments up to trace_depth_p
  - When the ring is full, the oldest entry is overwritten.
- freeze_i high in WAIT: FSM returns to IDLE with no completion recorded; lat_r is discarded.
- Read port: rd_v_i in cycle N gives rd_v_o=1 and rd_data_o in cycle N+1, showing the counter value before any cycle-N update. rd_addr_i >= num_ctr_lp returns 0. rd_data_o holds its value when rd_v_i=0.
- Trace port: entry = ring[(wptr-1-trace_idx_i) mod depth]. Indices >= trace_count_o return 0 on both outputs.
- miss_busy_o = (state==WAIT).

Test Plan:
- Reset, then 3 loads and 2 stores with freeze_i=0 plus 1 load with freeze_i=1 → counters 0/1/2 read 5/3/2, each with rd_v_o one cycle after rd_v_i.
- yumi at cycle 10, last at cycle 15, paddr 0x8000_0040 → latency 5, bin 1 (5>>2), counter4=5, trace_idx 0 returns {0x80000040, 5}, miss_busy_o high during cycles 11–15.
- yumi and last in the same cycle → latency 0, bin 0 +1, counter4 unchanged; latency 100 → bin 7 (clamped).
- 18 misses with latencies 1..18 → trace_count_o=16, idx 0 latency 18, idx 15 latency 3, idx wrap verified.
- yumi asserted again during WAIT → overlap counter=1, the original paddr is retained; freeze_i mid-WAIT → no completion, FSM back in IDLE.
- Preload counter 0 to all-ones via forced stimulus, then issue an access → value stays all-ones; rd_addr=num_ctr_lp → 0; clear_i concurrent with an access → all counters read 0.
